// File: rtl/ex_muldiv_stage.sv
// Back half of EX plus the EX/MEM pipeline register. Owns Hi/Lo and an iterative
// radix-2 multiply/divide unit that stalls the front end while it runs.
module ex_muldiv_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ITER = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Flush,
    input  logic [2:0]        cMulDivOp,
    input  logic [4:0]        cMemCtrl,
    input  logic [7:0]        cWBCtrl,
    input  logic              cZero,
    input  logic [XLEN-1:0]   PCPlus4,
    input  logic [XLEN-1:0]   PCSumImm,
    input  logic [XLEN-1:0]   ALUResult,
    input  logic [XLEN-1:0]   ReadReg1,
    input  logic [XLEN-1:0]   ReadReg2,
    input  logic [4:0]        RegDstResult,
    output logic              oStall,
    output logic [4:0]        ocMemCtrl,
    output logic [7:0]        ocWBCtrl,
    output logic              ocZero,
    output logic [XLEN-1:0]   oPCPlus4,
    output logic [XLEN-1:0]   oPCSumImm,
    output logic [XLEN-1:0]   oALUResult,
    output logic [XLEN-1:0]   oReadReg1,
    output logic [XLEN-1:0]   oReadReg2,
    output logic [4:0]        oRegDstResult,
    output logic [2*XLEN-1:0] oHiLoResult,
    output logic [XLEN-1:0]   oHi,
    output logic [XLEN-1:0]   oLo
);

    localparam int unsigned CntW = $clog2(ITER + 1);

    localparam logic [2:0] OpMult  = 3'd1;
    localparam logic [2:0] OpMultu = 3'd2;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpDivu  = 3'd4;
    localparam logic [2:0] OpMthi  = 3'd5;
    localparam logic [2:0] OpMtlo  = 3'd6;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   operand_q;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic              is_div_q;
    logic              neg_lo_q;
    logic              neg_hi_q;
    logic              div_zero_q;

    logic              is_md;
    logic              is_signed;
    logic              op_div;
    logic              divisor_zero;
    logic              start;
    logic              pass;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic              rem_ge;
    logic [XLEN-1:0]   rem_diff;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] result;

    always_comb begin
        is_md        = (cMulDivOp >= OpMult) && (cMulDivOp <= OpDivu);
        is_signed    = (cMulDivOp == OpMult) || (cMulDivOp == OpDiv);
        op_div       = (cMulDivOp == OpDiv) || (cMulDivOp == OpDivu);
        divisor_zero = (ReadReg2 == '0);
        mag_a        = (is_signed && ReadReg1[XLEN-1]) ? -ReadReg1 : ReadReg1;
        mag_b        = (is_signed && ReadReg2[XLEN-1]) ? -ReadReg2 : ReadReg2;

        start  = (state_q == StIdle) && is_md && !Flush;
        oStall = !Reset && (start || (state_q == StBusy));
        // EX/MEM takes the live inputs only for plain ops or the finishing mult/div.
        pass   = !Flush && (((state_q == StIdle) && !is_md) || (state_q == StDone));

        // Shift-add: acc = {partial product, remaining multiplier bits}.
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, operand_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};

        // Restoring divide: acc = {partial remainder, remaining dividend / quotient bits}.
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        rem_ge   = rem_sh >= {1'b0, operand_q};
        rem_diff = rem_sh[XLEN-1:0] - operand_q;
        div_next = rem_ge ? {rem_diff, acc_q[XLEN-2:0], 1'b1}
                          : {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

        if (div_zero_q) begin
            result = acc_q;
        end else if (is_div_q) begin
            result = {(neg_hi_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN]),
                      (neg_lo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0])};
        end else begin
            result = neg_lo_q ? -acc_q : acc_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            acc_q         <= '0;
            operand_q     <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            is_div_q      <= 1'b0;
            neg_lo_q      <= 1'b0;
            neg_hi_q      <= 1'b0;
            div_zero_q    <= 1'b0;
            ocMemCtrl     <= '0;
            ocWBCtrl      <= '0;
            ocZero        <= 1'b0;
            oPCPlus4      <= '0;
            oPCSumImm     <= '0;
            oALUResult    <= '0;
            oReadReg1     <= '0;
            oReadReg2     <= '0;
            oRegDstResult <= '0;
            oHiLoResult   <= '0;
        end else begin
            ocMemCtrl     <= pass ? cMemCtrl : '0;
            ocWBCtrl      <= pass ? cWBCtrl : '0;
            ocZero        <= pass & cZero;
            oPCPlus4      <= pass ? PCPlus4 : '0;
            oPCSumImm     <= pass ? PCSumImm : '0;
            oALUResult    <= pass ? ALUResult : '0;
            oReadReg1     <= pass ? ReadReg1 : '0;
            oReadReg2     <= pass ? ReadReg2 : '0;
            oRegDstResult <= pass ? RegDstResult : '0;
            oHiLoResult   <= '0;

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        operand_q  <= op_div ? mag_b : mag_a;
                        is_div_q   <= op_div;
                        neg_lo_q   <= is_signed && (ReadReg1[XLEN-1] ^ ReadReg2[XLEN-1]);
                        neg_hi_q   <= is_signed && ReadReg1[XLEN-1];
                        div_zero_q <= op_div && divisor_zero;
                        cnt_q      <= CntW'(ITER);
                        // Divide by zero preloads the architectural result and skips BUSY.
                        if (op_div && divisor_zero) begin
                            acc_q   <= {ReadReg1, {XLEN{1'b1}}};
                            state_q <= StDone;
                        end else begin
                            acc_q   <= {{XLEN{1'b0}}, (op_div ? mag_a : mag_b)};
                            state_q <= StBusy;
                        end
                    end else if (!Flush) begin
                        if (cMulDivOp == OpMthi) hi_q <= ReadReg1;
                        if (cMulDivOp == OpMtlo) lo_q <= ReadReg1;
                    end
                end
                StBusy: begin
                    if (Flush) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else begin
                        acc_q <= is_div_q ? div_next : mul_next;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CntW'(1)) state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    if (!Flush) begin
                        hi_q        <= result[2*XLEN-1:XLEN];
                        lo_q        <= result[XLEN-1:0];
                        oHiLoResult <= result;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign oHi = hi_q;
    assign oLo = lo_q;

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Scoreboarded bench for ex_muldiv_stage: driver pushes expected EX/MEM contents,
// a negedge monitor pops them whenever a tagged (non-bubble) instruction emerges.
module tb_ex_muldiv_stage;

    logic        Clk = 1'b0;
    logic        Reset, Flush, cZero;
    logic [2:0]  cMulDivOp;
    logic [4:0]  cMemCtrl, RegDstResult;
    logic [7:0]  cWBCtrl;
    logic [31:0] PCPlus4, PCSumImm, ALUResult, ReadReg1, ReadReg2;
    logic        oStall, ocZero;
    logic [4:0]  ocMemCtrl, oRegDstResult;
    logic [7:0]  ocWBCtrl;
    logic [31:0] oPCPlus4, oPCSumImm, oALUResult, oReadReg1, oReadReg2, oHi, oLo;
    logic [63:0] oHiLoResult;

    always #5 Clk = ~Clk;

    ex_muldiv_stage #(.XLEN(32), .ITER(32)) dut (
        .Clk(Clk), .Reset(Reset), .Flush(Flush), .cMulDivOp(cMulDivOp),
        .cMemCtrl(cMemCtrl), .cWBCtrl(cWBCtrl), .cZero(cZero),
        .PCPlus4(PCPlus4), .PCSumImm(PCSumImm), .ALUResult(ALUResult),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .RegDstResult(RegDstResult),
        .oStall(oStall), .ocMemCtrl(ocMemCtrl), .ocWBCtrl(ocWBCtrl), .ocZero(ocZero),
        .oPCPlus4(oPCPlus4), .oPCSumImm(oPCSumImm), .oALUResult(oALUResult),
        .oReadReg1(oReadReg1), .oReadReg2(oReadReg2), .oRegDstResult(oRegDstResult),
        .oHiLoResult(oHiLoResult), .oHi(oHi), .oLo(oLo)
    );

    typedef struct {
        logic [31:0] pc4, pcs, alu, rr1, rr2, hi, lo;
        logic [4:0]  rd, mem;
        logic [7:0]  wb;
        logic        zero;
        logic [63:0] hilo;
    } exp_t;

    exp_t        sbq[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;
    int          tag = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural mult/div results from plain integer arithmetic.
    function automatic logic [63:0] md_ref(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            3'd1: return sa * sb;
            3'd2: return ua * ub;
            3'd3: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd4: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            default: return 64'd0;
        endcase
    endfunction

    task automatic idle();
        Flush = 0; cMulDivOp = 0; cMemCtrl = 0; cWBCtrl = 0; cZero = 0;
        PCPlus4 = 0; PCSumImm = 0; ALUResult = 0; ReadReg1 = 0; ReadReg2 = 0;
        RegDstResult = 0;
    endtask

    // Issue one instruction and hold it until the stage accepts it.
    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit flush, input logic [4:0] mem, input logic [7:0] wb,
                       input logic zero, input logic [31:0] alu);
        exp_t        e;
        logic [63:0] r;
        bit          md, done;
        int          exp_st, stalls, bubbles;
        md     = (op >= 3'd1) && (op <= 3'd4);
        exp_st = (md && !flush) ? (((op == 3'd3 || op == 3'd4) && b == 0) ? 1 : 33) : 0;
        r      = 64'd0;
        if (!flush) begin
            if (md) begin
                r    = md_ref(op, a, b);
                hi_m = r[63:32];
                lo_m = r[31:0];
            end else if (op == 3'd5) begin
                hi_m = a;
            end else if (op == 3'd6) begin
                lo_m = a;
            end
        end
        cMulDivOp = op; ReadReg1 = a; ReadReg2 = b; Flush = flush; cMemCtrl = mem;
        cWBCtrl = wb; cZero = zero; ALUResult = alu; PCPlus4 = 32'(tag);
        PCSumImm = 32'(tag) * 4 + 32'h100; RegDstResult = 5'(tag);
        tag++;
        if (!flush) begin
            e.pc4 = PCPlus4; e.pcs = PCSumImm; e.alu = alu; e.rr1 = a; e.rr2 = b;
            e.rd = RegDstResult; e.mem = mem; e.wb = wb; e.zero = zero;
            e.hilo = r; e.hi = hi_m; e.lo = lo_m;
            sbq.push_back(e);
        end
        stalls = 0; bubbles = 0; done = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (!oStall) begin
                done = 1;
                break;
            end
            stalls++;
            @(posedge Clk); #1;
            if (oPCPlus4 == 0 && ocMemCtrl == 0 && ocWBCtrl == 0 && oALUResult == 0 &&
                oHiLoResult == 0 && oRegDstResult == 0) bubbles++;
        end
        check("stall_bounded", 64'(done), 64'd1);
        check("stall_cycles", 64'(stalls), 64'(exp_st));
        check("bubbles", 64'(bubbles), 64'(exp_st));
        @(posedge Clk); #1;
    endtask

    // Start a mult, then kill it with Flush or Reset during its 10th BUSY cycle.
    task automatic abort_mid(input bit use_reset);
        cMulDivOp = 3'd1; ReadReg1 = 32'h1234; ReadReg2 = 32'h5678; cMemCtrl = 5'h1F;
        cWBCtrl = 8'hFF; ALUResult = 32'h77; PCPlus4 = 32'(tag); PCSumImm = 32'h4;
        tag++;
        @(posedge Clk); #1;
        repeat (9) begin
            @(posedge Clk); #1;
        end
        if (use_reset) Reset = 1; else Flush = 1;
        @(negedge Clk);
        if (use_reset) check("reset_cycle_stall", 64'(oStall), 64'd0);
        @(posedge Clk); #1;
        Reset = 0;
        idle();
        #1;
        if (use_reset) begin
            hi_m = 0;
            lo_m = 0;
        end
        check("abort_stall", 64'(oStall), 64'd0);
        check("abort_hi", 64'(oHi), 64'(hi_m));
        check("abort_lo", 64'(oLo), 64'(lo_m));
        check("abort_bubble", {oPCPlus4, oALUResult}, 64'd0);
        check("abort_ctrl", {51'd0, ocMemCtrl, ocWBCtrl}, 64'd0);
        check("abort_hilores", oHiLoResult, 64'd0);
        @(posedge Clk); #1;
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (oPCPlus4 != 0) begin
            if (sbq.size() == 0) begin
                check("unexpected_output", 64'(oPCPlus4), 64'd0);
            end else begin
                e = sbq.pop_front();
                check("pcplus4", 64'(oPCPlus4), 64'(e.pc4));
                check("pcsumimm", 64'(oPCSumImm), 64'(e.pcs));
                check("aluresult", 64'(oALUResult), 64'(e.alu));
                check("readregs", {oReadReg1, oReadReg2}, {e.rr1, e.rr2});
                check("ctrl", {50'd0, ocMemCtrl, ocWBCtrl, ocZero},
                      {50'd0, e.mem, e.wb, e.zero});
                check("regdst", 64'(oRegDstResult), 64'(e.rd));
                check("hilores", oHiLoResult, e.hilo);
                check("hilo_regs", {oHi, oLo}, {e.hi, e.lo});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        bit          fl;
        idle();
        Reset = 1;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        check("reset_stall", 64'(oStall), 64'd0);
        check("reset_hilo", {oHi, oLo}, 64'd0);
        check("reset_outputs", {oPCPlus4, oALUResult}, 64'd0);
        check("reset_ctrl", {50'd0, ocMemCtrl, ocWBCtrl, ocZero}, 64'd0);
        check("reset_hilores", oHiLoResult, 64'd0);
        Reset = 0;

        run(3'd0, 32'h11, 32'h22, 0, 5'b10001, 8'h5A, 1'b1, 32'd5);
        check("pass_alu", 64'(oALUResult), 64'd5);
        check("pass_mem", 64'(ocMemCtrl), 64'b10001);
        check("pass_zero", 64'(ocZero), 64'd1);

        run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 5'h2, 8'h80, 1'b0, 32'h9);
        check("multu_hilores", oHiLoResult, 64'hFFFF_FFFE_0000_0001);
        check("multu_hi", 64'(oHi), 64'hFFFF_FFFE);
        check("multu_lo", 64'(oLo), 64'h1);
        run(3'd1, 32'hFFFF_FFFD, 32'd7, 0, 5'h0, 8'h80, 1'b0, 32'h0);
        check("mult_neg", {oHi, oLo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run(3'd3, 32'hFFFF_FFF9, 32'd2, 0, 5'h0, 8'h80, 1'b0, 32'h0);
        check("div_neg", {oHi, oLo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run(3'd4, 32'd100, 32'd7, 0, 5'h0, 8'h80, 1'b0, 32'h0);
        check("divu", {oHi, oLo}, {32'd2, 32'd14});
        run(3'd3, 32'h1234, 32'd0, 0, 5'h0, 8'h80, 1'b0, 32'h0);
        check("div_zero", {oHi, oLo}, 64'h0000_1234_FFFF_FFFF);

        abort_mid(0);
        abort_mid(1);

        run(3'd5, 32'hAAAA_5555, 32'd0, 0, 5'h0, 8'h0, 1'b0, 32'h0);
        check("mthi", 64'(oHi), 64'hAAAA_5555);
        run(3'd6, 32'h1234_5678, 32'd0, 0, 5'h0, 8'h0, 1'b0, 32'h0);
        check("mtlo", 64'(oLo), 64'h1234_5678);
        run(3'd6, 32'hDEAD_BEEF, 32'd0, 1, 5'h3, 8'h3, 1'b1, 32'h3);
        check("mtlo_flushed", 64'(oLo), 64'h1234_5678);

        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if (($urandom_range(0, 3) == 0)) b = 32'(b[3:0]);
            if ((op == 3'd3 || op == 3'd4) && $urandom_range(0, 3) == 0) b = 0;
            fl = ($urandom_range(0, 7) == 0);
            run(op, a, b, fl, 5'($urandom), 8'($urandom), 1'($urandom), $urandom);
        end

        idle();
        repeat (3) @(posedge Clk);
        #1;
        check("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
